// File: rtl/crypt_pkg.sv
// Shared constants, tap table and enumerations for the LFSR message crypt engine.
package crypt_pkg;

  localparam logic [7:0] SPACE = 8'h20;

  // Maximal-length 7-bit tap masks, indexed by pattern number.
  localparam logic [6:0] LFSR7_PTRN [9] = '{
    7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
  };

  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } crypt_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RD,
    ST_WR,
    ST_PAD,
    ST_DONE
  } crypt_state_e;

endpackage

// File: rtl/lfsr_step.sv
// Combinational LFSR next-state (shift left, XOR-of-taps feedback) and 7-bit parity helper.
module lfsr_step #(
  parameter int LFSR_W = 7
) (
  input  logic [LFSR_W-1:0] state,
  input  logic [LFSR_W-1:0] taps,
  input  logic [6:0]        par_data,
  output logic [LFSR_W-1:0] next_state,
  output logic              parity
);

  always_comb begin
    next_state = {state[LFSR_W-2:0], ^(state & taps)};
    parity     = ^par_data;
  end

endmodule

// File: rtl/lfsr_crypt_engine.sv
// Memory-mastering LFSR stream cipher: encrypts (with space padding and parity) or
// decrypts (with parity-error counting) a fixed-length block, using an init/req/ack handshake.
module lfsr_crypt_engine
  import crypt_pkg::*;
#(
  parameter int LFSR_W   = 7,
  parameter int MSG_LEN  = 64,
  parameter int ADDR_W   = 8,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 64
) (
  input  logic              clk,
  input  logic              init,
  input  logic              req,
  input  logic              mode,
  input  logic [7:0]        pre_len,
  input  logic [LFSR_W-1:0] taps,
  input  logic [LFSR_W-1:0] seed,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  output logic              ack,
  output logic [6:0]        err_cnt
);

  // Wide enough for MSG_LEN itself and for any unclamped 8-bit pre_len.
  localparam int IDX_W = ($clog2(MSG_LEN + 1) > 8) ? $clog2(MSG_LEN + 1) : 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  crypt_state_e      state, state_nx, byte_nx;
  crypt_mode_e       mode_q;
  logic [IDX_W-1:0]  idx, idx_inc, pre_q, pre_clamp;
  logic [LFSR_W-1:0] lfsr, lfsr_nx, taps_q;
  logic              term_q, term_nx, rd_term;
  logic [6:0]        err_q;
  logic              launch, last_byte, par;
  logic [6:0]        key, plain7, enc7, dec7, par_data;

  lfsr_step #(
    .LFSR_W(LFSR_W)
  ) u_step (
    .state     (lfsr),
    .taps      (taps_q),
    .par_data  (par_data),
    .next_state(lfsr_nx),
    .parity    (par)
  );

  always_comb begin
    pre_clamp = (int'(pre_len) >= MSG_LEN) ? IDX_W'(MSG_LEN) : IDX_W'(pre_len);
    launch    = (state == ST_ARMED) && !req;
    idx_inc   = idx + IDX_W'(1);
    last_byte = (idx == LAST_IDX);
    rd_term   = (state == ST_WR) && (mode_q == MODE_ENC) && (mem_rdata == 8'h00);
    term_nx   = term_q | rd_term;
    key       = 7'(lfsr);
    plain7    = ((state == ST_PAD) || rd_term) ? SPACE[6:0] : mem_rdata[6:0];
    enc7      = plain7 ^ key;
    dec7      = mem_rdata[6:0] ^ key;
    par_data  = (mode_q == MODE_DEC) ? mem_rdata[6:0] : enc7;
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    byte_nx  = ST_RD;
    if ((mode_q == MODE_ENC) && (term_nx || (idx_inc < pre_q))) begin
      byte_nx = ST_PAD;
    end
    case (state)
      ST_IDLE:  if (req) state_nx = ST_ARMED;
      ST_ARMED: begin
        if (!req) begin
          state_nx = ((mode == MODE_DEC) || (pre_clamp == '0)) ? ST_RD : ST_PAD;
        end
      end
      ST_RD:    state_nx = ST_WR;
      ST_WR,
      ST_PAD:   state_nx = last_byte ? ST_DONE : byte_nx;
      ST_DONE:  if (req) state_nx = ST_ARMED;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      idx    <= '0;
      pre_q  <= '0;
      mode_q <= MODE_ENC;
      lfsr   <= '0;
      taps_q <= '0;
      term_q <= 1'b0;
      err_q  <= '0;
    end else if (launch) begin
      idx    <= '0;
      pre_q  <= (mode == MODE_DEC) ? '0 : pre_clamp;
      mode_q <= crypt_mode_e'(mode);
      lfsr   <= (seed == '0) ? LFSR_W'(1) : seed;
      taps_q <= taps;
      term_q <= 1'b0;
      err_q  <= '0;
    end else if ((state == ST_WR) || (state == ST_PAD)) begin
      idx    <= idx_inc;
      lfsr   <= lfsr_nx;
      term_q <= term_nx;
      if ((state == ST_WR) && (mode_q == MODE_DEC) && (mem_rdata[7] != par) &&
          (err_q != '1)) begin
        err_q <= err_q + 7'd1;
      end
    end
  end

  // Source reads lag the output index by the pad count (zero in decrypt mode).
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ack       = 1'b0;
    case (state)
      ST_RD: begin
        mem_rd   = 1'b1;
        mem_addr = ADDR_W'(SRC_BASE) + ADDR_W'(idx - pre_q);
      end
      ST_WR,
      ST_PAD: begin
        mem_wr    = 1'b1;
        mem_addr  = ADDR_W'(DST_BASE) + ADDR_W'(idx);
        mem_wdata = (mode_q == MODE_DEC) ? {1'b0, dec7} : {par, enc7};
      end
      ST_DONE: ack = 1'b1;
      default: ;
    endcase
    err_cnt = err_q;
  end

endmodule

// File: tb/tb_lfsr_crypt_engine.sv
// Directed self-checking bench for lfsr_crypt_engine with a behavioural memory and keystream model.
module tb_lfsr_crypt_engine;

  logic       clk = 1'b0;
  logic       init, req, mode;
  logic [7:0] pre_len;
  logic [6:0] taps, seed;
  logic [7:0] mem_addr, mem_rdata, mem_wdata;
  logic       mem_rd, mem_wr, ack;
  logic [6:0] err_cnt;

  logic [7:0] mem [0:255];
  logic       tb_we;
  logic [7:0] tb_wa, tb_wd;
  logic       mon_clr;
  int         rd_cnt, wr_cnt, both_cnt, addr_err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_buf [64];
  logic [6:0] ptrn [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
  logic [7:0] pad_exp [7] = '{8'h21, 8'h22, 8'h24, 8'h28, 8'h30, 8'h00, 8'hE1};
  string      msg = "Mr. Watson, come here. I want to see you.";

  lfsr_crypt_engine #(
    .LFSR_W(7), .MSG_LEN(64), .ADDR_W(8), .SRC_BASE(0), .DST_BASE(64)
  ) dut (
    .clk(clk), .init(init), .req(req), .mode(mode), .pre_len(pre_len),
    .taps(taps), .seed(seed), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .ack(ack), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    else if (tb_we) mem[tb_wa] <= tb_wd;
  end

  always @(negedge clk) begin
    if (mon_clr) begin
      rd_cnt <= 0; wr_cnt <= 0; both_cnt <= 0; addr_err <= 0;
    end else begin
      if (mem_rd) rd_cnt <= rd_cnt + 1;
      if (mem_rd && mem_wr) both_cnt <= both_cnt + 1;
      if (mem_wr) begin
        wr_cnt <= wr_cnt + 1;
        if (mem_addr != 8'(64 + wr_cnt)) addr_err <= addr_err + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic load_msg();
    for (int i = 0; i < msg.len(); i++) poke(8'(i), msg[i]);
    poke(8'(msg.len()), 8'h00);
  endtask

  function automatic logic [6:0] step(input logic [6:0] s, input logic [6:0] t);
    return {s[5:0], ^(s & t)};
  endfunction

  task automatic build_enc(input logic [6:0] t, input logic [6:0] s0, input int pre);
    logic [6:0] s, o;
    logic [7:0] p;
    bit         term;
    s = (s0 == 7'd0) ? 7'd1 : s0;
    term = 1'b0;
    if (pre > 64) pre = 64;
    for (int i = 0; i < 64; i++) begin
      if (i < pre || term) p = 8'h20;
      else if (mem[i - pre] == 8'h00) begin term = 1'b1; p = 8'h20; end
      else p = mem[i - pre];
      o = p[6:0] ^ s;
      exp_buf[i] = {^o, o};
      s = step(s, t);
    end
  endtask

  task automatic start(input logic m, input logic [7:0] pl, input logic [6:0] t, input logic [6:0] s);
    @(posedge clk); #1;
    mode = m; pre_len = pl; taps = t; seed = s; req = 1'b1; mon_clr = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; mon_clr = 1'b0;
    @(posedge clk);
  endtask

  task automatic wait_ack(input bit toggle, output int cycles);
    bit done = 1'b0;
    cycles = 0;
    while (!done && cycles < 1000) begin
      @(posedge clk); #1;
      cycles++;
      if (toggle && cycles == 30) req = 1'b1;
      if (toggle && cycles == 31) req = 1'b0;
      if (ack) done = 1'b1;
    end
    chk("ack_seen", 32'(done), 32'd1);
  endtask

  task automatic check_run(input string tag, input int cyc, input int exp_cyc, input int exp_rd);
    chk({tag, "_cycles"}, cyc, exp_cyc);
    chk({tag, "_reads"}, rd_cnt, exp_rd);
    chk({tag, "_writes"}, wr_cnt, 64);
    chk({tag, "_addr_order"}, addr_err, 0);
    chk({tag, "_rd_wr_overlap"}, both_cnt, 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_mem_rd"}, 32'(mem_rd), 0);
    chk({tag, "_mem_wr"}, 32'(mem_wr), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
  endtask

  initial begin
    int         cyc;
    logic [6:0] tr, sr;
    logic [7:0] b;

    init = 1'b1; req = 1'b0; mode = 1'b0; pre_len = '0; taps = '0; seed = '0;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0; mon_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    init = 1'b0;

    // All-pad encrypt block.
    start(1'b0, 8'd64, 7'h60, 7'h01);
    wait_ack(1'b0, cyc);
    check_run("allpad", cyc, 64, 0);
    for (int i = 0; i < 7; i++) chk($sformatf("allpad_byte%0d", i), 32'(mem[64 + i]), 32'(pad_exp[i]));
    chk("allpad_ack_held", 32'(ack), 1);

    // Message encrypt, random tap pattern and seed.
    load_msg();
    tr = ptrn[$urandom_range(8, 0)];
    sr = 7'($urandom_range(127, 1));
    build_enc(tr, sr, 10);
    start(1'b0, 8'd10, tr, sr);
    wait_ack(1'b0, cyc);
    check_run("enc", cyc, 106, 42);
    for (int i = 0; i < 64; i++) chk($sformatf("enc_byte%0d", i), 32'(mem[64 + i]), 32'(exp_buf[i]));

    // Round trip: ciphertext becomes the source; req toggles mid-run.
    for (int i = 0; i < 64; i++) poke(8'(i), mem[64 + i]);
    start(1'b1, 8'd0, tr, sr);
    wait_ack(1'b1, cyc);
    check_run("dec", cyc, 128, 64);
    chk("dec_err_cnt", 32'(err_cnt), 0);
    for (int i = 0; i < 64; i++) begin
      b = (i >= 10 && i <= 50) ? msg[i - 10] : 8'h20;
      chk($sformatf("dec_byte%0d", i), 32'(mem[64 + i]), 32'(b));
    end

    // Parity error on source byte 3.
    poke(8'd3, mem[3] ^ 8'h80);
    start(1'b1, 8'd0, tr, sr);
    wait_ack(1'b0, cyc);
    chk("par_err_cnt", 32'(err_cnt), 1);
    chk("par_byte3", 32'(mem[67]), 32'h20);
    chk("par_byte10", 32'(mem[74]), 32'(msg[0]));

    // Zero seed acts as seed 1; oversize pre_len clamps to all pad.
    build_enc(7'h60, 7'h00, 200);
    start(1'b0, 8'd200, 7'h60, 7'h00);
    wait_ack(1'b0, cyc);
    check_run("seed0", cyc, 64, 0);
    for (int i = 0; i < 7; i++) chk($sformatf("seed0_hand%0d", i), 32'(mem[64 + i]), 32'(pad_exp[i]));
    for (int i = 0; i < 64; i++) chk($sformatf("seed0_byte%0d", i), 32'(mem[64 + i]), 32'(exp_buf[i]));

    // Abort mid-run with init, then relaunch an encrypt.
    load_msg();
    start(1'b1, 8'd0, tr, sr);
    repeat (20) @(posedge clk);
    #1;
    init = 1'b1;
    @(posedge clk); #1;
    check_reset("abort");
    init = 1'b0;
    build_enc(tr, sr, 10);
    start(1'b0, 8'd10, tr, sr);
    wait_ack(1'b0, cyc);
    check_run("relaunch", cyc, 106, 42);
    for (int i = 0; i < 64; i++) chk($sformatf("relaunch_byte%0d", i), 32'(mem[64 + i]), 32'(exp_buf[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_crypt_engine.md
# lfsr_crypt_engine

Hardware successor to the software LFSR message-encryption program: a parametrised, memory-mastering engine that encrypts or decrypts a fixed-length message block with a maximal-length LFSR keystream. It sits beside the data memory in `top_level` and uses the same `init`/`req`/`ack` launch protocol as the CPU. Width, block length and memory layout are parameters, and tap patterns are supplied at run time. Beyond the encrypt-only program it adds a decrypt mode and parity-error counting.

## Interface
- `LFSR_W`, 7: LFSR state width; keystream uses bits `[LFSR_W-1:0]`, data width fixed at 8.
- `MSG_LEN`, 64: output block length in bytes.
- `ADDR_W`, 8: memory address width.
- `SRC_BASE`, 0: first source byte address.
- `DST_BASE`, 64: first destination byte address.
- `clk` in 1: single clock, rising edge.
- `init` in 1: reset, synchronous, active-high.
- `req` in 1: launch request; a run starts after `req` falls.
- `mode` in 1: 0 = encrypt, 1 = decrypt; sampled at launch.
- `pre_len` in 8: leading space count (encrypt); sampled at launch.
- `taps` in LFSR_W: feedback tap mask; sampled at launch.
- `seed` in LFSR_W: LFSR start state; sampled at launch.
- `mem_addr` out ADDR_W: memory address.
- `mem_rd` out 1: read strobe; data returns on `mem_rdata` next cycle.
- `mem_rdata` in 8: read data.
- `mem_wr` out 1: write strobe, committed at clock edge.
- `mem_wdata` out 8: write data.
- `ack` out 1: run complete; held until next `req` high or `init`.
- `err_cnt` out 7: decrypt parity-error count; valid while `ack` is high.

## Operation
- The LFSR steps once per output byte: `next = {s[LFSR_W-2:0], ^(s & taps)}`. If `seed` is 0, the engine loads 1.
- Byte i uses keystream state `lfsr[i]`, with `lfsr[0] = seed`.
- **Encrypt:**
  - Padded byte p[i] = 0x20 for i < `pre_len`.
  - For i ≥ `pre_len`, p[i] = src[i-`pre_len`] until the first 0x00 source byte. That terminator and all later bytes become 0x20.
  - Out[6:0] = p[6:0] ^ lfsr[i]; out[7] = ^out[6:0]. Input bit 7 is ignored.
  - Source reads stop at the terminator or at `MSG_LEN-pre_len` bytes, whichever comes first.
  - `pre_len` ≥ `MSG_LEN` is clamped; the output is then all pad.
- **Decrypt:**
  - Reads all `MSG_LEN` source bytes.
  - Out = {1'b0, src[6:0] ^ lfsr[i]}.
  - `err_cnt` increments (saturating at 127) when src[7] ≠ ^src[6:0].
- FSM states: IDLE, ARMED, RD, WR, PAD, DONE.
  - IDLE → ARMED when `req`=1.
  - ARMED → first work state when `req`=0; the launch inputs are latched on this transition.
  - RD asserts `mem_rd`, then → WR.
  - WR writes the byte using `mem_rdata`.
  - PAD writes 0x20-derived bytes without any read.
  - After byte `MSG_LEN-1` is written → DONE.
  - DONE → ARMED when `req`=1.
- `req` toggling during a run is ignored. `init` at any cycle forces IDLE and aborts any partial writes.

## Timing
- Reset values: `ack`=0, `mem_rd`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0, `err_cnt`=0.
- Each read byte takes 2 cycles (RD, WR). Each pad byte takes 1 cycle (PAD).
- Encrypt run length = pre_len' + 2·k + (terminator read ? 2 : 0) + remaining pads, where pre_len' is the clamped `pre_len` and k is the number of message characters.
- Decrypt run length = 2·`MSG_LEN` cycles.
- `ack` rises in the cycle after the last write.
- `mem_rd` and `mem_wr` are never asserted in the same cycle.
- Write addresses are `DST_BASE+i`, strictly increasing with no gaps.

## Structure
- Package `crypt_pkg`:
  - `SPACE` = 8'h20.
  - `LFSR7_PTRN[9]` = 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B, so software can map a pattern number to a tap mask.
  - `crypt_mode_e` and the FSM state enum.
- Sub-module `lfsr_step`: purely combinational next-state and parity helper, parametrised by `LFSR_W`.

## Test plan
- Encrypt, all-pad block: `taps`=0x60, `seed`=0x01, `pre_len`=64 → DST bytes 0..6 = 0x21, 0x22, 0x24, 0x28, 0x30, 0x00, 0xE1; no reads issued; `ack` after 64 cycles.
- Encrypt "Mr. Watson, come here. I want to see you." with `pre_len`=10, random taps from `LFSR7_PTRN` and random seed → all 64 bytes match the behavioural model; reads stop at the terminator.
- Round trip: decrypt the previous output back into memory → bytes 10..50 equal the message ASCII values; `err_cnt`=0.
- Decrypt with src[3] bit 7 flipped → `err_cnt`=1; byte 3 is still decrypted correctly.
- `seed`=0 behaves identically to `seed`=1; `pre_len`=200 gives an all-pad output.
- `init` pulsed mid-run → outputs return to reset values next cycle; `req` high then low relaunches and completes correctly.
